rv32i_multicycle_ctrl: RTL
==========================

Name: rv32i_multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core.
- Sequences fetch, decode, execute, memory and writeback for each instruction held in the datapath IR.
- Drives PC, IR, ALU, memory and regfile control signals using the rv32i_opcodes, ALU_FNS and LOAD_STORE_FNS encodings.
- Handles waited memory accesses via mem_ready, and halts on illegal, system or bus-timeout conditions.

Parameters:
- TIMEOUT, 255, maximum cycles to wait for mem_ready in any wait state; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  IR contents; stable from the cycle after ir_wr.
- mem_ready  in  1  memory completes the current access this cycle.
- branch_taken  in  1  datapath comparator result for BRANCH funct3.
- pc_wr  out  1  load PC this cycle.
- pc_src  out  2  0=PC+4, 1=PC+imm, 2=ALU-out register.
- ir_wr  out  1  load IR from memory read data.
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request.
- ls_funct3  out  3  access size/sign (LOAD_STORE_FNS funct3_t); instr[14:12] in MEM.
- alu_src_a  out  2  0=rs1, 1=PC, 2=zero.
- alu_src_b  out  1  0=rs2, 1=immediate.
- alu_fn  out  3  alu_fn_t.
- alu_alt  out  1  SUB/SRA select.
- regfile_wr  out  1  write rd.
- regfile_src  out  2  regfile_load_t.
- illegal  out  1  sticky: illegal instruction encountered.
- bus_err  out  1  sticky: memory timeout.
- halted  out  1  FSM is in HALT.

Behaviour:
- Reset: synchronous. While rst=1 all outputs are 0 and the state is FETCH. The first FETCH cycle occurs on the first clock edge with rst=0.
- Outputs are combinational from the state register and instr.
- The datapath ALU-out register loads every cycle.
- FETCH: mem_rd=1, alu_src_a=PC. Hold until mem_ready=1; in that cycle ir_wr=1, next state DECODE.
- DECODE (1 cycle), next state chosen by opcode:
  - EXECUTE for OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - MISC_MEM: pc_wr=1, pc_src=0, next FETCH (NOP).
  - SYSTEM: next HALT.
  - Any other opcode, or instr[1:0]!=11: illegal<=1, next HALT.
- EXECUTE:
  - OP: alu_src_a=0, alu_src_b=0, alu_fn=funct3, alu_alt=instr[30].
  - OP_IMM: alu_src_b=1, alu_fn=funct3, alu_alt=instr[30] only when funct3=SRL_SRA, else 0.
  - LUI: alu_src_a=2, alu_src_b=1, ADD.
  - AUIPC: alu_src_a=1, alu_src_b=1, ADD.
  - LOAD/STORE: rs1+imm (ADD), next MEM.
  - JALR: rs1+imm, next WRITEBACK.
  - JAL: next WRITEBACK.
  - BRANCH: pc_wr=1, pc_src = branch_taken ? 1 : 0, next FETCH.
  - All others: next WRITEBACK.
- MEM:
  - LOAD asserts mem_rd; STORE asserts mem_wr. Held until mem_ready.
  - On mem_ready: a load goes to WRITEBACK; a store sets pc_wr=1, pc_src=0 and goes to FETCH.
  - Illegal funct3 (load 011/110/111; store >010) is detected in DECODE: illegal<=1, HALT, no memory access issued.
- WRITEBACK: regfile_wr=1 (suppressed when rd=0), pc_wr=1.
  - OP/OP_IMM/LUI/AUIPC: regfile_src=FROM_ALU, pc_src=0.
  - LOAD: regfile_src=FROM_MEM, pc_src=0.
  - JAL: regfile_src=FROM_PC_PLUS_4, pc_src=1.
  - JALR: regfile_src=FROM_PC_PLUS_4, pc_src=2.
  - Next FETCH.
- pc_wr is asserted exactly once per retired instruction, always in the instruction's final state.
- Wait counter:
  - Resets on entry to FETCH or MEM and counts cycles with mem_ready=0.
  - If TIMEOUT!=0 and the count reaches TIMEOUT: bus_err<=1, mem_rd/mem_wr drop that cycle, next HALT.
- HALT: halted=1 and all strobes 0. Remains until rst.
- Reset mid-access: requests drop in the reset cycle and no pc_wr, regfile_wr or ir_wr is issued. illegal and bus_err clear only on rst.
- Latency with zero-wait memory:
  - ALU, LUI, AUIPC, JAL, JALR, LOAD: 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK), plus 1 for LOAD (MEM) = 5.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
  - MISC_MEM: 2 cycles.

Test Plan:
- Reset then ADD x3,x1,x2 (0x002081B3), mem_ready=1 always -> ir_wr at cycle 1; alu_fn=0, alu_alt=0 in EXECUTE; regfile_wr=1, regfile_src=FROM_ALU, pc_wr=1 in cycle 4.
- SUB x3,x1,x2 (0x402081B3), then SRAI x5,x5,3 (0x4032D293), then ADDI x0,x0,0 -> alu_alt=1 in both SUB and SRAI EXECUTE; the ADDI WRITEBACK has regfile_wr=0 but pc_wr=1.
- LW x4,8(x1) (0x0080A203), mem_ready low 3 cycles in MEM -> mem_rd held 4 cycles with ls_funct3=010; then WRITEBACK with regfile_src=FROM_MEM; 8 cycles total.
- BEQ with branch_taken=1, then branch_taken=0 -> pc_wr=1 in cycle 3 with pc_src=1, then pc_src=0; regfile_wr never asserted.
- JALR x1,0(x5) (0x000280E7) -> WRITEBACK: regfile_src=FROM_PC_PLUS_4, pc_src=2. Opcode 0x00000000 -> illegal=1, halted=1, no further mem_rd.
- TIMEOUT=4, mem_ready held 0 in FETCH -> mem_rd high for 4 cycles, then bus_err=1, halted=1. Asserting rst returns to FETCH with all flags 0.

Source files
------------

// File: rtl/rv32i_multicycle_ctrl_if.sv
// Control/datapath bundle for the RV32I multi-cycle controller.
// master = controller side, slave = datapath/memory side.
interface rv32i_multicycle_ctrl_if;
    logic [31:0] instr;
    logic        mem_ready;
    logic        branch_taken;
    logic        pc_wr;
    logic [1:0]  pc_src;
    logic        ir_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  ls_funct3;
    logic [1:0]  alu_src_a;
    logic        alu_src_b;
    logic [2:0]  alu_fn;
    logic        alu_alt;
    logic        regfile_wr;
    logic [1:0]  regfile_src;
    logic        illegal;
    logic        bus_err;
    logic        halted;

    modport master (
        input  instr, mem_ready, branch_taken,
        output pc_wr, pc_src, ir_wr, mem_rd, mem_wr, ls_funct3,
               alu_src_a, alu_src_b, alu_fn, alu_alt,
               regfile_wr, regfile_src, illegal, bus_err, halted
    );

    modport slave (
        output instr, mem_ready, branch_taken,
        input  pc_wr, pc_src, ir_wr, mem_rd, mem_wr, ls_funct3,
               alu_src_a, alu_src_b, alu_fn, alu_alt,
               regfile_wr, regfile_src, illegal, bus_err, halted
    );
endinterface

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH / DECODE / EXECUTE / MEM / WRITEBACK,
// waited memory via mem_ready with an optional bus timeout, sticky halt flags.
module rv32i_multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    rv32i_multicycle_ctrl_if.master bus
);
    // rv32i_opcodes
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // ALU_FNS / LOAD_STORE_FNS
    localparam logic [2:0] ALU_ADD     = 3'b000;
    localparam logic [2:0] ALU_SRL_SRA = 3'b101;
    localparam logic [2:0] LS_W        = 3'b010;

    // regfile_load_t
    localparam logic [1:0] FROM_ALU       = 2'd0;
    localparam logic [1:0] FROM_MEM       = 2'd1;
    localparam logic [1:0] FROM_PC_PLUS_4 = 2'd2;

    localparam logic [1:0] PC_PLUS_4 = 2'd0;
    localparam logic [1:0] PC_IMM    = 2'd1;
    localparam logic [1:0] PC_ALU    = 2'd2;

    localparam logic [1:0] A_RS1  = 2'd0;
    localparam logic [1:0] A_PC   = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
    } state_t;

    state_t        state_q, state_d;
    logic          illegal_q, illegal_d;
    logic          bus_err_q, bus_err_d;
    logic [CW-1:0] wcnt_q, wcnt_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       rd_nz;
    logic       timeout;
    logic       dec_exec;

    logic       pc_wr_c, ir_wr_c, mem_rd_c, mem_wr_c, alu_src_b_c, alu_alt_c;
    logic       regfile_wr_c, halted_c;
    logic [1:0] pc_src_c, alu_src_a_c, regfile_src_c;
    logic [2:0] ls_funct3_c, alu_fn_c;

    assign opcode  = bus.instr[6:0];
    assign funct3  = bus.instr[14:12];
    assign rd_nz   = |bus.instr[11:7];
    assign timeout = (TIMEOUT != 0) && (wcnt_q == CW'(TIMEOUT));

    // Opcodes that proceed to EXECUTE; bad load/store sizes are rejected here
    // so no memory access is ever issued for them.
    always_comb begin
        dec_exec = 1'b0;
        case (opcode)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
            OPC_JAL, OPC_JALR, OPC_BRANCH: dec_exec = 1'b1;
            OPC_LOAD:  dec_exec = !(funct3 == 3'b011 || funct3[2:1] == 2'b11);
            OPC_STORE: dec_exec = (funct3 <= 3'b010);
            default:   dec_exec = 1'b0;
        endcase
    end

    // Next-state, sticky flags, wait counter and per-state control outputs.
    always_comb begin
        state_d       = state_q;
        illegal_d     = illegal_q;
        bus_err_d     = bus_err_q;
        wcnt_d        = '0;
        pc_wr_c       = 1'b0;
        pc_src_c      = PC_PLUS_4;
        ir_wr_c       = 1'b0;
        mem_rd_c      = 1'b0;
        mem_wr_c      = 1'b0;
        ls_funct3_c   = 3'b000;
        alu_src_a_c   = A_RS1;
        alu_src_b_c   = 1'b0;
        alu_fn_c      = ALU_ADD;
        alu_alt_c     = 1'b0;
        regfile_wr_c  = 1'b0;
        regfile_src_c = FROM_ALU;
        halted_c      = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_a_c = A_PC;
                ls_funct3_c = LS_W;  // instruction fetch is a word access
                if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    mem_rd_c = 1'b1;
                    if (bus.mem_ready) begin
                        ir_wr_c = 1'b1;
                        state_d = S_DECODE;
                    end else if (TIMEOUT != 0) begin
                        wcnt_d = wcnt_q + CW'(1);
                    end
                end
            end
            S_DECODE: begin
                if (dec_exec) begin
                    state_d = S_EXECUTE;
                end else if (opcode == OPC_MISC_MEM) begin
                    pc_wr_c = 1'b1;
                    state_d = S_FETCH;
                end else if (opcode == OPC_SYSTEM) begin
                    state_d = S_HALT;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_EXECUTE: begin
                state_d = S_WB;
                case (opcode)
                    OPC_OP: begin
                        alu_fn_c  = funct3;
                        alu_alt_c = bus.instr[30];
                    end
                    OPC_OP_IMM: begin
                        alu_src_b_c = 1'b1;
                        alu_fn_c    = funct3;
                        alu_alt_c   = (funct3 == ALU_SRL_SRA) && bus.instr[30];
                    end
                    OPC_LUI: begin
                        alu_src_a_c = A_ZERO;
                        alu_src_b_c = 1'b1;
                    end
                    OPC_AUIPC: begin
                        alu_src_a_c = A_PC;
                        alu_src_b_c = 1'b1;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        alu_src_b_c = 1'b1;
                        state_d     = S_MEM;
                    end
                    OPC_JALR: alu_src_b_c = 1'b1;
                    OPC_BRANCH: begin
                        pc_wr_c  = 1'b1;
                        pc_src_c = bus.branch_taken ? PC_IMM : PC_PLUS_4;
                        state_d  = S_FETCH;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                ls_funct3_c = funct3;
                if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    mem_rd_c = (opcode == OPC_LOAD);
                    mem_wr_c = (opcode == OPC_STORE);
                    if (bus.mem_ready) begin
                        if (opcode == OPC_STORE) begin
                            pc_wr_c = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end else if (TIMEOUT != 0) begin
                        wcnt_d = wcnt_q + CW'(1);
                    end
                end
            end
            S_WB: begin
                regfile_wr_c = rd_nz;
                pc_wr_c      = 1'b1;
                state_d      = S_FETCH;
                case (opcode)
                    OPC_LOAD: regfile_src_c = FROM_MEM;
                    OPC_JAL: begin
                        regfile_src_c = FROM_PC_PLUS_4;
                        pc_src_c      = PC_IMM;
                    end
                    OPC_JALR: begin
                        regfile_src_c = FROM_PC_PLUS_4;
                        pc_src_c      = PC_ALU;
                    end
                    default: regfile_src_c = FROM_ALU;
                endcase
            end
            S_HALT:  halted_c = 1'b1;
            default: state_d = S_HALT;
        endcase
    end

    // State and sticky flags; everything clears only on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            wcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            wcnt_q    <= wcnt_d;
        end
    end

    // Reset forces every output low in the same cycle, dropping any request.
    assign bus.pc_wr       = pc_wr_c & ~rst;
    assign bus.pc_src      = rst ? 2'd0 : pc_src_c;
    assign bus.ir_wr       = ir_wr_c & ~rst;
    assign bus.mem_rd      = mem_rd_c & ~rst;
    assign bus.mem_wr      = mem_wr_c & ~rst;
    assign bus.ls_funct3   = rst ? 3'd0 : ls_funct3_c;
    assign bus.alu_src_a   = rst ? 2'd0 : alu_src_a_c;
    assign bus.alu_src_b   = alu_src_b_c & ~rst;
    assign bus.alu_fn      = rst ? 3'd0 : alu_fn_c;
    assign bus.alu_alt     = alu_alt_c & ~rst;
    assign bus.regfile_wr  = regfile_wr_c & ~rst;
    assign bus.regfile_src = rst ? 2'd0 : regfile_src_c;
    assign bus.illegal     = illegal_q & ~rst;
    assign bus.bus_err     = bus_err_q & ~rst;
    assign bus.halted      = halted_c & ~rst;
endmodule
